// File: rtl/unidade_controle.sv
// Multicycle control FSM for the MIPS-subset datapath: decodes opcode/funct and
// sequences mux selects and write enables as a Moore machine.
module unidade_controle #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            zero,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            ALUOutWrite,
    output logic            RegDst,
    output logic            MemToReg,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            excecao,
    output logic [ST_W-1:0] estado
);

    localparam logic [ST_W-1:0] S_RESET      = ST_W'(0);
    localparam logic [ST_W-1:0] S_FETCH      = ST_W'(1);
    localparam logic [ST_W-1:0] S_FETCH_WAIT = ST_W'(2);
    localparam logic [ST_W-1:0] S_DECODE     = ST_W'(3);
    localparam logic [ST_W-1:0] S_R_EXEC     = ST_W'(4);
    localparam logic [ST_W-1:0] S_R_WB       = ST_W'(5);
    localparam logic [ST_W-1:0] S_MEM_ADDR   = ST_W'(6);
    localparam logic [ST_W-1:0] S_MEM_READ   = ST_W'(7);
    localparam logic [ST_W-1:0] S_MEM_WAIT   = ST_W'(8);
    localparam logic [ST_W-1:0] S_LW_WB      = ST_W'(9);
    localparam logic [ST_W-1:0] S_MEM_WRITE  = ST_W'(10);
    localparam logic [ST_W-1:0] S_BRANCH     = ST_W'(11);
    localparam logic [ST_W-1:0] S_JUMP       = ST_W'(12);
    localparam logic [ST_W-1:0] S_ADDI_EXEC  = ST_W'(13);
    localparam logic [ST_W-1:0] S_ADDI_WB    = ST_W'(14);
    localparam logic [ST_W-1:0] S_EXCECAO    = ST_W'(15);

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic [ST_W-1:0] r_estado;
    logic [ST_W-1:0] w_proximo;
    logic            w_funct_ok;

    assign w_funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                        (funct == 6'h25) || (funct == 6'h2A);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= S_RESET;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = S_RESET;
        case (r_estado)
            S_RESET:      w_proximo = S_FETCH;
            S_FETCH:      w_proximo = S_FETCH_WAIT;
            S_FETCH_WAIT: w_proximo = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h00:        w_proximo = w_funct_ok ? S_R_EXEC : S_EXCECAO;
                    6'h23, 6'h2B: w_proximo = S_MEM_ADDR;
                    6'h04:        w_proximo = S_BRANCH;
                    6'h02:        w_proximo = S_JUMP;
                    6'h08:        w_proximo = S_ADDI_EXEC;
                    default:      w_proximo = S_EXCECAO;
                endcase
            end
            S_R_EXEC:     w_proximo = S_R_WB;
            S_R_WB:       w_proximo = S_FETCH;
            // Only lw/sw reach MEM_ADDR, so anything other than sw is treated as lw.
            S_MEM_ADDR:   w_proximo = (opcode == 6'h2B) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:   w_proximo = S_MEM_WAIT;
            S_MEM_WAIT:   w_proximo = S_LW_WB;
            S_LW_WB:      w_proximo = S_FETCH;
            S_MEM_WRITE:  w_proximo = S_FETCH;
            S_BRANCH:     w_proximo = S_FETCH;
            S_JUMP:       w_proximo = S_FETCH;
            S_ADDI_EXEC:  w_proximo = S_ADDI_WB;
            S_ADDI_WB:    w_proximo = S_FETCH;
            S_EXCECAO:    w_proximo = S_EXCECAO;
            default:      w_proximo = S_RESET;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ALUOutWrite = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = OP_IDLE;
        PCSource    = 2'b00;
        excecao     = 1'b0;
        case (r_estado)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                ALUOp   = OP_ADD;
                PCWrite = 1'b1;
            end
            S_FETCH_WAIT: IRWrite = 1'b1;
            S_DECODE: begin
                ALUSrcB     = 2'b11;
                ALUOp       = OP_ADD;
                ALUOutWrite = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUOutWrite = 1'b1;
                case (funct)
                    6'h20:   ALUOp = OP_ADD;
                    6'h22:   ALUOp = OP_SUB;
                    6'h24:   ALUOp = OP_AND;
                    6'h25:   ALUOp = OP_OR;
                    6'h2A:   ALUOp = OP_SLT;
                    default: ALUOp = OP_IDLE;
                endcase
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALUOp       = OP_ADD;
                ALUOutWrite = 1'b1;
            end
            S_MEM_READ, S_MEM_WAIT: IorD = 1'b1;
            S_LW_WB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = OP_SUB;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_ADDI_WB:  RegWrite = 1'b1;
            S_EXCECAO:  excecao  = 1'b1;
            default: ;
        endcase
    end

    assign estado = r_estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: table of instruction sequences with a
// scoreboard of per-cycle expected control words, plus reset/exception corner cases.
module tb_unidade_controle;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, ALUOutWrite;
    logic       RegDst, MemToReg, RegWrite, ALUSrcA, excecao;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] w_estado;

    unidade_controle #(.ST_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ALUOutWrite(ALUOutWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .excecao(excecao), .estado(w_estado)
    );

    always #5 clk = ~clk;

    typedef enum logic [3:0] {
        L_RESET, L_F, L_FW, L_D, L_RX, L_RWB, L_MA, L_MR, L_MW, L_LWB,
        L_MWR, L_BR, L_J, L_AX, L_AWB, L_EXC
    } lbl_t;

    typedef struct packed {
        logic       pcw, pcwc, iord, memw, irw, aluoutw, regdst, memtoreg, regw, srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       exc;
    } ctrl_t;

    typedef struct {
        string          name;
        logic [5:0]     opc;
        logic [5:0]     fn;
        logic           z;
        int unsigned    n;
        logic [6:0][3:0] path;
    } vec_t;

    typedef struct {
        string name;
        ctrl_t exp;
    } sb_t;

    ctrl_t w_act;
    assign w_act = {PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, ALUOutWrite, RegDst,
                    MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, excecao};

    int    n_tests = 0;
    int    n_fail  = 0;
    sb_t   sb_q[$];
    vec_t  vecs[$];

    function automatic ctrl_t exp_ctrl(lbl_t l, logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (l)
            L_F:   begin c.srcb = 2'b01; c.aluop = 3'b001; c.pcw = 1'b1; end
            L_FW:  c.irw = 1'b1;
            L_D:   begin c.srcb = 2'b11; c.aluop = 3'b001; c.aluoutw = 1'b1; end
            L_RX: begin
                c.srca = 1'b1; c.srcb = 2'b00; c.aluoutw = 1'b1;
                case (fn)
                    6'h20: c.aluop = 3'b001;
                    6'h22: c.aluop = 3'b010;
                    6'h24: c.aluop = 3'b011;
                    6'h25: c.aluop = 3'b100;
                    6'h2A: c.aluop = 3'b111;
                    default: c.aluop = 3'b000;
                endcase
            end
            L_RWB: begin c.regdst = 1'b1; c.regw = 1'b1; end
            L_MA, L_AX: begin c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b001; c.aluoutw = 1'b1; end
            L_MR, L_MW: c.iord = 1'b1;
            L_LWB: begin c.memtoreg = 1'b1; c.regw = 1'b1; end
            L_MWR: begin c.iord = 1'b1; c.memw = 1'b1; end
            L_BR:  begin c.srca = 1'b1; c.aluop = 3'b010; c.pcsrc = 2'b01; c.pcwc = 1'b1; end
            L_J:   begin c.pcsrc = 2'b10; c.pcw = 1'b1; end
            L_AWB: c.regw = 1'b1;
            L_EXC: c.exc = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic vec_t mk(string nm, logic [5:0] o, logic [5:0] f, logic z,
                                int unsigned n, logic [6:0][3:0] p);
        vec_t v;
        v.name = nm; v.opc = o; v.fn = f; v.z = z; v.n = n; v.path = p;
        return v;
    endfunction

    task automatic check(input string nm, input ctrl_t act, input ctrl_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ctrl=%h required %h", nm, act, exp);
        end
    endtask

    // Inputs are randomised in states where the FSM must not look at them.
    task automatic step(input lbl_t l, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input string nm);
        sb_t it;
        @(posedge clk); #1;
        if (l inside {L_D, L_RX, L_MA, L_BR}) begin
            opcode = o; funct = f; zero = z;
        end else begin
            opcode = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
        end
        it.name = nm;
        it.exp  = exp_ctrl(l, f);
        sb_q.push_back(it);
    endtask

    task automatic release_reset();
        sb_t it;
        @(posedge clk); #1;
        reset = 1'b0;
        it.name = "reset_cycle";
        it.exp  = '0;
        sb_q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_t it;
            it = sb_q.pop_front();
            check(it.name, w_act, it.exp);
        end
    end

    initial begin
        vecs.push_back(mk("add",  6'h00, 6'h20, 1'b0, 5, {8'h0, L_RWB, L_RX, L_D, L_FW, L_F}));
        vecs.push_back(mk("sub",  6'h00, 6'h22, 1'b0, 5, {8'h0, L_RWB, L_RX, L_D, L_FW, L_F}));
        vecs.push_back(mk("and",  6'h00, 6'h24, 1'b1, 5, {8'h0, L_RWB, L_RX, L_D, L_FW, L_F}));
        vecs.push_back(mk("or",   6'h00, 6'h25, 1'b0, 5, {8'h0, L_RWB, L_RX, L_D, L_FW, L_F}));
        vecs.push_back(mk("slt",  6'h00, 6'h2A, 1'b1, 5, {8'h0, L_RWB, L_RX, L_D, L_FW, L_F}));
        vecs.push_back(mk("lw",   6'h23, 6'h11, 1'b0, 7, {L_LWB, L_MW, L_MR, L_MA, L_D, L_FW, L_F}));
        vecs.push_back(mk("sw",   6'h2B, 6'h05, 1'b1, 5, {8'h0, L_MWR, L_MA, L_D, L_FW, L_F}));
        vecs.push_back(mk("beq1", 6'h04, 6'h00, 1'b1, 4, {12'h0, L_BR, L_D, L_FW, L_F}));
        vecs.push_back(mk("beq0", 6'h04, 6'h3F, 1'b0, 4, {12'h0, L_BR, L_D, L_FW, L_F}));
        vecs.push_back(mk("j",    6'h02, 6'h20, 1'b0, 4, {12'h0, L_J, L_D, L_FW, L_F}));
        vecs.push_back(mk("addi", 6'h08, 6'h2A, 1'b1, 5, {8'h0, L_AWB, L_AX, L_D, L_FW, L_F}));

        reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hold", w_act, '0);

        release_reset();
        $display("[TB] estado after reset release = %0d", w_estado);
        foreach (vecs[i]) begin
            for (int unsigned k = 0; k < vecs[i].n; k++) begin
                step(lbl_t'(vecs[i].path[k]), vecs[i].opc, vecs[i].fn, vecs[i].z,
                     $sformatf("%s_c%0d", vecs[i].name, k));
            end
        end
        step(L_F, 6'h00, 6'h00, 1'b0, "final_fetch");

        // Illegal opcode: trapped, then held for 20 cycles of noisy inputs
        step(L_FW, 6'h00, 6'h00, 1'b0, "ill_fw");
        step(L_D, 6'h3F, 6'h20, 1'b0, "ill_dec");
        for (int i = 0; i < 20; i++) step(L_EXC, 6'h00, 6'h00, 1'b0, $sformatf("ill_hold%0d", i));
        @(posedge clk); #1;
        check("ill_before_reset", w_act, exp_ctrl(L_EXC, 6'h00));
        #1 reset = 1'b1;
        #1 check("ill_async_clear", w_act, '0);

        // R-type with an invalid funct
        release_reset();
        step(L_F, 6'h00, 6'h00, 1'b0, "badf_f");
        step(L_FW, 6'h00, 6'h00, 1'b0, "badf_fw");
        step(L_D, 6'h00, 6'h07, 1'b0, "badf_dec");
        for (int i = 0; i < 20; i++) step(L_EXC, 6'h00, 6'h00, 1'b0, $sformatf("badf_hold%0d", i));
        @(posedge clk); #2;
        check("badf_before_reset", w_act, exp_ctrl(L_EXC, 6'h00));
        reset = 1'b1;
        #1 check("badf_async_clear", w_act, '0);

        // Jump aborted by reset asserted inside the JUMP state
        release_reset();
        step(L_F, 6'h00, 6'h00, 1'b0, "jab_f");
        step(L_FW, 6'h00, 6'h00, 1'b0, "jab_fw");
        step(L_D, 6'h02, 6'h00, 1'b0, "jab_dec");
        @(posedge clk); #1;
        opcode = 6'h23; funct = 6'h2B; zero = 1'b1;
        #1 check("jab_jump", w_act, exp_ctrl(L_J, 6'h00));
        reset = 1'b1;
        #1 check("jab_abort", w_act, '0);
        @(posedge clk); #1;
        check("jab_held", w_act, '0);

        release_reset();
        step(L_F, 6'h00, 6'h00, 1'b0, "restart_f");
        step(L_FW, 6'h00, 6'h00, 1'b0, "restart_fw");
        @(negedge clk); #1;

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
Multicycle control FSM for the MIPS-subset datapath. It decodes opcode/funct and sequences the datapath mux selects and write enables, including the 2-bit ALUSrcB select for the ALU B-operand mux. This block drives ALUSrcB; the mux consumes it. It sits beside the datapath, fed from the instruction register fields and the ALU zero flag.

Parameters:
ST_W, 4, width of the state register / estado debug port

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0], used only when opcode=0x00
zero  input  1  ALU zero flag, sampled in BRANCH state
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if zero=1
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
ALUOutWrite  output  1  ALUOut register load
RegDst  output  1  dest register: 0=rt, 1=rd
MemToReg  output  1  write-back data: 0=ALUOut, 1=MDR
RegWrite  output  1  register file write
ALUSrcA  output  1  0=PC, 1=regA
ALUSrcB  output  2  00=regB, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2
ALUOp  output  3  001=ADD, 010=SUB, 011=AND, 100=OR, 111=SLT, 000=idle
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump address
excecao  output  1  invalid instruction detected, sticky
estado  output  ST_W  current state, for debug

Behaviour:
- Moore machine: outputs decode combinationally from the state register only. Any signal not listed for a state is 0.
- Asynchronous reset: state=RESET immediately, so all outputs are 0 and excecao=0. RESET lasts 1 cycle after deassertion, then goes to FETCH. Reset mid-instruction aborts it with no further write enables.
- Memory read latency is 1 cycle; data is valid in the cycle after the address is presented.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1. Goes to FETCH_WAIT.
- FETCH_WAIT: IRWrite=1. Goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD, ALUOutWrite=1 (branch target). Next state by opcode:
  - 0x00 with valid funct -> R_EXEC
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDI_EXEC
  - anything else, including opcode 0x00 with invalid funct -> EXCECAO
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOutWrite=1. ALUOp by funct: 0x20=ADD, 0x22=SUB, 0x24=AND, 0x25=OR, 0x2A=SLT. Goes to R_WB.
- R_WB: RegDst=1, MemToReg=0, RegWrite=1. Goes to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, ALUOutWrite=1. lw goes to MEM_READ; sw goes to MEM_WRITE.
- MEM_READ: IorD=1. Goes to MEM_WAIT.
- MEM_WAIT: IorD=1; the MDR captures memory data. Goes to LW_WB.
- LW_WB: RegDst=0, MemToReg=1, RegWrite=1. Goes to FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, PCWriteCond=1. Goes to FETCH.
- JUMP: PCSource=10, PCWrite=1. Goes to FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD, ALUOutWrite=1. Goes to ADDI_WB.
- ADDI_WB: RegDst=0, MemToReg=0, RegWrite=1. Goes to FETCH.
- EXCECAO: excecao=1 and all enables 0. Terminal; only reset leaves it.
- Cycle counts from FETCH to the next FETCH: R-type 5, lw 7, sw 5, beq 4, j 4, addi 5.
- opcode, funct and zero are ignored outside DECODE, R_EXEC, MEM_ADDR and BRANCH. Changing them in other states has no effect.
- Illegal state encodings go to RESET on the next clock.

Test Plan:
- Reset held, then released with opcode=0x00, funct=0x20 -> all outputs 0 during reset; RESET 1 cycle; then states FETCH, FETCH_WAIT, DECODE, R_EXEC (ALUSrcB=00, ALUOp=001), R_WB (RegWrite=1, RegDst=1), FETCH.
- lw (opcode=0x23) -> ALUSrcB: FETCH=01, DECODE=11, MEM_ADDR=10; MemToReg=1 and RegWrite=1 only in LW_WB, 7 cycles after FETCH; MemWrite never 1.
- sw (opcode=0x2B) -> MemWrite=1 for exactly 1 cycle, in the 5th cycle; RegWrite stays 0 throughout.
- beq (opcode=0x04) with zero=1, then with zero=0 -> BRANCH asserts PCWriteCond=1, PCSource=01, ALUOp=010; 4-cycle instruction in both cases.
- opcode=0x3F, then separately opcode=0x00 with funct=0x07 -> reaches EXCECAO after DECODE with excecao=1, stays there 20 cycles despite input changes; asynchronous reset clears it mid-cycle.
- j (opcode=0x02), then reset asserted during the JUMP state -> outputs go to 0 immediately without waiting for a clock edge, and PCWrite drops.
